// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - CHARIS instruction fetch stage
//
// Holds the PC, fetches one word at a time from a variable-latency instruction
// memory, and presents the word as Instr/Instr_valid to control and decode.
// Build option: IF_PERF_CNT_EN adds the perf_fetched / perf_stall counters.
//
// Ports:
//   Clk, Reset        clock (rising edge), async active-low reset
//   PC_Sel            0 = PC+4, 1 = PC+4+(PC_Immed<<2)
//   PC_LdEn           advance PC and consume the current Instr
//   PC_Immed          sign-extended branch offset in words
//   imem_req          one-cycle fetch request pulse
//   imem_addr         fetch byte address (always equal to PC)
//   imem_rdata        returned instruction word
//   imem_rvalid       imem_rdata valid this cycle
//   Instr             registered instruction
//   Instr_valid       Instr holds an unconsumed fetched word
//   PC                current PC
//   fetch_err         sticky, at least one fetch timeout since reset
//   perf_fetched      (IF_PERF_CNT_EN) completed fetches
//   perf_stall        (IF_PERF_CNT_EN) ISSUE cycles without PC_LdEn

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          TO_W     = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PC_Sel,
  input  logic        PC_LdEn,
  input  logic [31:0] PC_Immed,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] Instr,
  output logic        Instr_valid,
  output logic [31:0] PC,
  output logic        fetch_err
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic [31:0]     pc_plus4;
  logic [31:0]     next_pc;

  // to_cnt is 0 in the first WAIT cycle, so the TIMEOUT-th WAIT cycle is the last.
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

  // Shifting the full word by 2 equals {PC_Immed[29:0],2'b00}; wrap is silent.
  assign pc_plus4 = PC + 32'd4;
  assign next_pc  = PC_Sel ? (pc_plus4 + (PC_Immed << 2)) : pc_plus4;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_REQ;
      S_REQ:   state_next = S_WAIT;
      S_WAIT: begin
        // A response on the timeout cycle still wins over the re-issue.
        if (imem_rvalid) begin
          state_next = S_ISSUE;
        end else if (timeout_hit) begin
          state_next = S_REQ;
        end
      end
      S_ISSUE: begin
        if (PC_LdEn) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req = (state == S_REQ);
  end

  assign imem_addr = PC;

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      PC          <= RESET_PC;
      Instr       <= 32'h0;
      Instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      to_cnt      <= '0;
    end else begin
      case (state)
        S_REQ: begin
          to_cnt <= '0;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (imem_rvalid) begin
            Instr       <= imem_rdata;
            Instr_valid <= 1'b1;
          end else if (timeout_hit) begin
            fetch_err <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (PC_LdEn) begin
            PC          <= next_pc;
            Instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (state == S_WAIT && imem_rvalid) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (state == S_ISSUE && !PC_LdEn) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage

module tb_if_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        PC_Sel;
  logic        PC_LdEn;
  logic [31:0] PC_Immed;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC;
  logic        fetch_err;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16),
    .TO_W     (5)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PC_Sel      (PC_Sel),
    .PC_LdEn     (PC_LdEn),
    .PC_Immed    (PC_Immed),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .PC          (PC),
    .fetch_err   (fetch_err)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Starts in a REQ cycle; the memory answers in WAIT cycle 'lat'. Ends in ISSUE.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
    check("req_pulse", {31'b0, imem_req}, 32'd1);
    check("req_addr", imem_addr, addr);
    tick;
    check("req_drop", {31'b0, imem_req}, 32'd0);
    repeat (lat - 1) tick;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick;
    imem_rvalid = 1'b0;
    check("valid_up", {31'b0, Instr_valid}, 32'd1);
    check("instr", Instr, data);
    check("issue_pc", PC, addr);
  endtask

  // Drive control inputs for the current ISSUE cycle and take the edge.
  task automatic issue(input logic sel, input logic ld, input logic [31:0] immed);
    PC_Sel   = sel;
    PC_LdEn  = ld;
    PC_Immed = immed;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset       = 1'b0;
    PC_Sel      = 1'b0;
    PC_LdEn     = 1'b0;
    PC_Immed    = 32'h0;
    imem_rdata  = 32'h0;
    imem_rvalid = 1'b0;
    tick;
    tick;
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, 32'h0);
    check("rst_valid", {31'b0, Instr_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);

    // Back-to-back fetches with PC_LdEn held high: 3-cycle period.
    Reset   = 1'b1;
    PC_LdEn = 1'b1;
    check("idle_req", {31'b0, imem_req}, 32'd0);
    tick;
    fetch(32'h0, 32'h8000_0003, 1);
    tick;
    check("consumed", {31'b0, Instr_valid}, 32'd0);
    fetch(32'h4, 32'h8000_0003, 1);
    tick;
    fetch(32'h8, 32'h8000_0003, 1);

    // Walk to 0x10, then branch back by -2 words and forward by +5 words.
    issue(1'b0, 1'b1, 32'h0);
    fetch(32'hC, 32'h1111_0000, 2);
    issue(1'b0, 1'b1, 32'h0);
    fetch(32'h10, 32'h2222_0000, 1);
    issue(1'b1, 1'b1, 32'hFFFF_FFFE);
    fetch(32'hC, 32'h3333_0000, 1);
    issue(1'b0, 1'b1, 32'h0);
    fetch(32'h10, 32'h4444_0000, 1);
    issue(1'b1, 1'b1, 32'h0000_0005);
    fetch(32'h28, 32'h1234_5678, 1);

    // Seven stall cycles; rvalid and branch inputs must not disturb ISSUE.
    PC_LdEn     = 1'b0;
    PC_Sel      = 1'b1;
    PC_Immed    = 32'h7;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 7; i++) begin
      tick;
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_valid", {31'b0, Instr_valid}, 32'd1);
      check("stall_instr", Instr, 32'h1234_5678);
      check("stall_pc", PC, 32'h28);
    end
    imem_rvalid = 1'b0;
`ifdef IF_PERF_CNT_EN
    check("perf_stall", perf_stall, 32'd7);
    check("perf_fetched", perf_fetched, 32'd8);
`endif

    // Branch to 0x20 (0x28+4-12), then reset in the middle of WAIT.
    issue(1'b1, 1'b1, 32'hFFFF_FFFD);
    check("br_addr", imem_addr, 32'h20);
    tick;
    tick;
    #2;
    Reset = 1'b0;
    #1;
    check("async_pc", PC, 32'h0);
    check("async_valid", {31'b0, Instr_valid}, 32'd0);
    check("async_instr", Instr, 32'h0);
    check("async_req", {31'b0, imem_req}, 32'd0);
    tick;
    tick;
    Reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_0001;
    tick;
    check("rst_req_addr", imem_addr, 32'h0);
    check("rst_req_pulse", {31'b0, imem_req}, 32'd1);
    check("stale_idle", {31'b0, Instr_valid}, 32'd0);
    tick;
    check("stale_req", {31'b0, Instr_valid}, 32'd0);
    imem_rvalid = 1'b0;

    // Response on the 16th WAIT cycle is accepted without a timeout.
    repeat (15) tick;
    check("w16_req", {31'b0, imem_req}, 32'd0);
    check("w16_err", {31'b0, fetch_err}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_F00D;
    tick;
    imem_rvalid = 1'b0;
    check("late_valid", {31'b0, Instr_valid}, 32'd1);
    check("late_instr", Instr, 32'h0BAD_F00D);
    check("late_err", {31'b0, fetch_err}, 32'd0);

    // No response at all: timeout after 16 WAIT cycles, same address re-issued.
    issue(1'b0, 1'b1, 32'h0);
    check("to_first_addr", imem_addr, 32'h4);
    tick;
    repeat (15) tick;
    check("to_pre_err", {31'b0, fetch_err}, 32'd0);
    check("to_pre_req", {31'b0, imem_req}, 32'd0);
    tick;
    check("to_err", {31'b0, fetch_err}, 32'd1);
    fetch(32'h4, 32'hCAFE_0001, 3);
    check("err_sticky", {31'b0, fetch_err}, 32'd1);

    // Branch to 0xFFFF_FFFC (4+4-12), then sequential wrap to 0.
    issue(1'b1, 1'b1, 32'hFFFF_FFFD);
    fetch(32'hFFFF_FFFC, 32'h5555_AAAA, 1);
    issue(1'b0, 1'b1, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", {31'b0, imem_req}, 32'd1);
    check("wrap_pc", PC, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage for the single-cycle CHARIS datapath. It sits directly upstream of the control unit and decode stage.
- Holds the PC and issues word fetches to an instruction memory whose read latency varies.
- Registers the returned word as Instr and presents it with Instr_valid.
- Computes the next PC from the control unit's PC_Sel/PC_LdEn and the decoded branch immediate.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
TIMEOUT, 16, max cycles in WAIT before the fetch is re-issued (>=2).
TO_W, 5, width of timeout counter (must hold TIMEOUT).

Ports:
Clk  in  1  clock; all state on rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
PC_Sel  in  1  from control: 0 = PC+4, 1 = PC+4+(PC_Immed<<2)
PC_LdEn  in  1  from control: advance PC and consume current Instr
PC_Immed  in  32  sign-extended branch offset in words, from decode
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  32  byte address of fetch (= PC)
imem_rdata  in  32  returned instruction word
imem_rvalid  in  1  imem_rdata valid this cycle
Instr  out  32  registered instruction to control/decode
Instr_valid  out  1  Instr holds a fetched word not yet consumed
PC  out  32  current PC
fetch_err  out  1  sticky: at least one timeout occurred since reset

Behaviour:
- Reset (Reset=0, async): PC=RESET_PC, Instr=32'h0, Instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0, state=IDLE. Downstream must gate on Instr_valid, because 32'h0 decodes as beq.
- FSM states: IDLE, REQ, WAIT, ISSUE.
- IDLE: one cycle after reset release, then -> REQ.
- REQ: imem_req=1, imem_addr=PC for exactly this cycle; counter cleared; -> WAIT.
- WAIT: counter increments each cycle.
  - imem_rvalid=1: Instr<=imem_rdata, Instr_valid<=1, -> ISSUE.
  - Counter reaches TIMEOUT-1 with no rvalid: fetch_err<=1, -> REQ (same PC re-fetched).
  - rvalid on the timeout cycle wins: data is accepted and fetch_err is not set.
- ISSUE: Instr_valid=1 and Instr is stable.
  - PC_LdEn=1: PC<=next_pc, Instr_valid<=0, -> REQ.
  - PC_LdEn=0: stall; remain in ISSUE holding Instr and PC unchanged, indefinitely.
- next_pc arithmetic: PC+4 if PC_Sel=0, else PC+4+{PC_Immed[29:0],2'b00}.
  - 32-bit modulo; wrap-around silent (32'hFFFF_FFFC+4 -> 0).
  - PC[1:0] is always 00.
- PC_Sel/PC_LdEn/PC_Immed are sampled only in ISSUE; ignored in all other states.
- imem_rvalid in IDLE, REQ or ISSUE is ignored; no state change.
- Fetch-to-valid latency: Instr_valid rises 1 cycle after the rvalid cycle. Minimum fetch period is 3 cycles: REQ, WAIT (rvalid), ISSUE.
- Reset mid-WAIT: the outstanding fetch is abandoned and the memory must drop it. After release the sequence restarts at IDLE with PC=RESET_PC.
- imem_addr = PC at all times; meaningful only when imem_req=1.

Optional Feature:
Macro: IF_PERF_CNT_EN
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0, both wrap at 2^32.
  - perf_fetched: +1 on each WAIT->ISSUE transition.
  - perf_stall: +1 on each ISSUE cycle with PC_LdEn=0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Reset, memory returns rvalid 1 cycle after req, rdata=32'h8000_0003, PC_LdEn=1 held -> imem_addr sequence 0,4,8; Instr=32'h8000_0003 with Instr_valid for 1 cycle per fetch; 3-cycle period.
2. In ISSUE at PC=32'h10 with PC_Sel=1, PC_LdEn=1, PC_Immed=32'hFFFF_FFFE -> next imem_addr=32'h0C. With PC_Immed=5 -> 32'h28.
3. Hold PC_LdEn=0 for 7 cycles in ISSUE -> Instr, PC and Instr_valid=1 unchanged; no imem_req. With IF_PERF_CNT_EN defined, perf_stall=7.
4. Withhold rvalid for TIMEOUT=16 cycles -> fetch_err=1; imem_req re-pulses with the same addr. rvalid arriving on cycle 16 of WAIT -> accepted, fetch_err stays 0.
5. Assert Reset=0 mid-WAIT at PC=32'h20 -> outputs go to reset values immediately; after release, first imem_addr=RESET_PC; stale rvalid during IDLE is ignored.
6. PC=32'hFFFF_FFFC, PC_Sel=0, PC_LdEn=1 -> next imem_addr=32'h0000_0000.
